// File: rtl/bsg_cache_decode_stage.sv
// Registered cache opcode decoder with a 2-entry skid buffer and saturating illegal-opcode counter.
// Define BSG_CACHE_DECODE_STAGE_STATS_EN to add per-class legal-opcode counters.

package bsg_cache_decode_stage_pkg;
   typedef struct packed {
      logic       ld_op;
      logic       st_op;
      logic       amo_op;
      logic       mgmt_op;
      logic       mask_op;
      logic       sigext;
      logic [1:0] size;
      logic [2:0] mgmt_sel;
      logic [3:0] amo_subop;
      logic       illegal;
   } decode_s;
endpackage

module bsg_cache_decode_stage
   import bsg_cache_decode_stage_pkg::*;
#(
   parameter int unsigned data_width_p  = 64,
   parameter int unsigned amo_support_p = 1,
   parameter int unsigned cnt_width_p   = 16
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   v_i,
   input  logic [5:0]             opcode_i,
   output logic                   ready_o,
   output logic                   v_o,
   input  logic                   yumi_i,
   output logic                   ld_op_o,
   output logic                   st_op_o,
   output logic                   amo_op_o,
   output logic                   mgmt_op_o,
   output logic                   mask_op_o,
   output logic                   sigext_o,
   output logic [1:0]             size_o,
   output logic [2:0]             mgmt_sel_o,
   output logic [3:0]             amo_subop_o,
   output logic                   illegal_o,
   output logic [cnt_width_p-1:0] illegal_cnt_o,
   input  logic                   clear_cnt_i
`ifdef BSG_CACHE_DECODE_STAGE_STATS_EN
   ,
   output logic [cnt_width_p-1:0] ld_cnt_o,
   output logic [cnt_width_p-1:0] st_cnt_o,
   output logic [cnt_width_p-1:0] amo_cnt_o,
   output logic [cnt_width_p-1:0] mgmt_cnt_o
`endif
);

   localparam int unsigned          max_size_lp = $clog2(data_width_p / 8);
   localparam logic [1:0]           size_max_lp = 2'(max_size_lp);
   localparam logic [cnt_width_p-1:0] cnt_max_lp = '1;

   function automatic logic [cnt_width_p-1:0] sat_cnt(input logic [cnt_width_p-1:0] c,
                                                      input logic inc, input logic clr);
      if (clr) return '0;
      if (inc && (c != cnt_max_lp)) return c + cnt_width_p'(1);
      return c;
   endfunction

   decode_s dec_c;
   logic    legal_c;

   // Input-side decode; illegal opcodes collapse to an all-zero payload with only illegal set
   always_comb begin
      dec_c   = '0;
      legal_c = 1'b0;
      case (opcode_i[5:4])
         2'b00: begin
            if (!opcode_i[3]) begin
               dec_c.ld_op  = 1'b1;
               dec_c.sigext = ~opcode_i[2];
               dec_c.size   = opcode_i[1:0];
               legal_c      = (opcode_i[1:0] <= size_max_lp);
            end else if (opcode_i[2:0] == 3'b000) begin
               dec_c.ld_op   = 1'b1;
               dec_c.mask_op = 1'b1;
               dec_c.size    = size_max_lp;
               legal_c       = 1'b1;
            end
         end
         2'b10: begin
            if (opcode_i[3:2] == 2'b00) begin
               dec_c.st_op = 1'b1;
               dec_c.size  = opcode_i[1:0];
               legal_c     = (opcode_i[1:0] <= size_max_lp);
            end else if (opcode_i[3:0] == 4'h8) begin
               dec_c.st_op   = 1'b1;
               dec_c.mask_op = 1'b1;
               dec_c.size    = size_max_lp;
               legal_c       = 1'b1;
            end
         end
         2'b01: begin
            if (!opcode_i[3]) begin
               dec_c.mgmt_op  = 1'b1;
               dec_c.mgmt_sel = opcode_i[2:0];
               legal_c        = 1'b1;
            end
         end
         2'b11: begin
            if ((amo_support_p != 0) && (opcode_i[3:0] <= 4'h8)) begin
               dec_c.amo_op    = 1'b1;
               dec_c.amo_subop = opcode_i[3:0];
               dec_c.size      = size_max_lp;
               legal_c         = 1'b1;
            end
         end
      endcase
      if (!legal_c) begin
         dec_c         = '0;
         dec_c.illegal = 1'b1;
      end
   end

   decode_s                 head_d, head_q, tail_d, tail_q;
   logic [1:0]              cnt_d, cnt_q;
   logic                    v_d, v_q, ready_d, ready_q;
   logic                    push_c, pop_c;
   logic [cnt_width_p-1:0]  illegal_cnt_d, illegal_cnt_q;

   // Skid buffer: head is what the consumer sees, tail only fills while head is stalled
   always_comb begin
      push_c = v_i & ready_q;
      pop_c  = v_q & yumi_i;
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      case ({push_c, pop_c})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
      if (pop_c && (cnt_q == 2'd2)) begin
         head_d = tail_q;
      end else if (push_c && ((cnt_q == 2'd0) || pop_c)) begin
         head_d = dec_c;
      end
      if (push_c && !pop_c && (cnt_q == 2'd1)) begin
         tail_d = dec_c;
      end
      v_d           = (cnt_d != 2'd0);
      ready_d       = (cnt_d < 2'd2);
      illegal_cnt_d = sat_cnt(illegal_cnt_q, push_c & dec_c.illegal, clear_cnt_i);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         head_q        <= '0;
         tail_q        <= '0;
         cnt_q         <= 2'd0;
         v_q           <= 1'b0;
         ready_q       <= 1'b1;
         illegal_cnt_q <= '0;
      end else begin
         head_q        <= head_d;
         tail_q        <= tail_d;
         cnt_q         <= cnt_d;
         v_q           <= v_d;
         ready_q       <= ready_d;
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   assign ready_o       = ready_q;
   assign v_o           = v_q;
   assign ld_op_o       = head_q.ld_op;
   assign st_op_o       = head_q.st_op;
   assign amo_op_o      = head_q.amo_op;
   assign mgmt_op_o     = head_q.mgmt_op;
   assign mask_op_o     = head_q.mask_op;
   assign sigext_o      = head_q.sigext;
   assign size_o        = head_q.size;
   assign mgmt_sel_o    = head_q.mgmt_sel;
   assign amo_subop_o   = head_q.amo_subop;
   assign illegal_o     = head_q.illegal;
   assign illegal_cnt_o = illegal_cnt_q;

`ifdef BSG_CACHE_DECODE_STAGE_STATS_EN
   logic [cnt_width_p-1:0] ld_cnt_d, ld_cnt_q, st_cnt_d, st_cnt_q;
   logic [cnt_width_p-1:0] amo_cnt_d, amo_cnt_q, mgmt_cnt_d, mgmt_cnt_q;

   // Class bits are already zero for illegal opcodes, so these count legal accepts only
   always_comb begin
      ld_cnt_d   = sat_cnt(ld_cnt_q,   push_c & dec_c.ld_op,   clear_cnt_i);
      st_cnt_d   = sat_cnt(st_cnt_q,   push_c & dec_c.st_op,   clear_cnt_i);
      amo_cnt_d  = sat_cnt(amo_cnt_q,  push_c & dec_c.amo_op,  clear_cnt_i);
      mgmt_cnt_d = sat_cnt(mgmt_cnt_q, push_c & dec_c.mgmt_op, clear_cnt_i);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ld_cnt_q   <= '0;
         st_cnt_q   <= '0;
         amo_cnt_q  <= '0;
         mgmt_cnt_q <= '0;
      end else begin
         ld_cnt_q   <= ld_cnt_d;
         st_cnt_q   <= st_cnt_d;
         amo_cnt_q  <= amo_cnt_d;
         mgmt_cnt_q <= mgmt_cnt_d;
      end
   end

   assign ld_cnt_o   = ld_cnt_q;
   assign st_cnt_o   = st_cnt_q;
   assign amo_cnt_o  = amo_cnt_q;
   assign mgmt_cnt_o = mgmt_cnt_q;
`endif

endmodule

// File: tb/tb_bsg_cache_decode_stage.sv
// Directed bench for bsg_cache_decode_stage: two configurations (64b/AMO/16b count and
// 32b/no-AMO/2b count) driven in lockstep, checked against a reference decode and scoreboard.

module tb_bsg_cache_decode_stage;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       v_i = 1'b0;
   logic [5:0] opcode_i = 6'h0;
   logic       yumi_i = 1'b0;
   logic       clear_cnt_i = 1'b0;

   logic        ready_a, v_a, ld_a, st_a, amo_a, mg_a, mk_a, sx_a, il_a;
   logic [1:0]  size_a;
   logic [2:0]  msel_a;
   logic [3:0]  asub_a;
   logic [15:0] cnt_a;
   logic        ready_b, v_b, ld_b, st_b, amo_b, mg_b, mk_b, sx_b, il_b;
   logic [1:0]  size_b;
   logic [2:0]  msel_b;
   logic [3:0]  asub_b;
   logic [1:0]  cnt_b;
`ifdef BSG_CACHE_DECODE_STAGE_STATS_EN
   logic [15:0] lda, sta, amoa, mga;
   logic [1:0]  ldb, stb, amob, mgb;
`endif

   always #5 clk = ~clk;

   bsg_cache_decode_stage #(.data_width_p(64), .amo_support_p(1), .cnt_width_p(16)) dut_a (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .opcode_i(opcode_i), .ready_o(ready_a),
      .v_o(v_a), .yumi_i(yumi_i), .ld_op_o(ld_a), .st_op_o(st_a), .amo_op_o(amo_a),
      .mgmt_op_o(mg_a), .mask_op_o(mk_a), .sigext_o(sx_a), .size_o(size_a),
      .mgmt_sel_o(msel_a), .amo_subop_o(asub_a), .illegal_o(il_a),
      .illegal_cnt_o(cnt_a), .clear_cnt_i(clear_cnt_i)
`ifdef BSG_CACHE_DECODE_STAGE_STATS_EN
      , .ld_cnt_o(lda), .st_cnt_o(sta), .amo_cnt_o(amoa), .mgmt_cnt_o(mga)
`endif
   );

   bsg_cache_decode_stage #(.data_width_p(32), .amo_support_p(0), .cnt_width_p(2)) dut_b (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .opcode_i(opcode_i), .ready_o(ready_b),
      .v_o(v_b), .yumi_i(yumi_i), .ld_op_o(ld_b), .st_op_o(st_b), .amo_op_o(amo_b),
      .mgmt_op_o(mg_b), .mask_op_o(mk_b), .sigext_o(sx_b), .size_o(size_b),
      .mgmt_sel_o(msel_b), .amo_subop_o(asub_b), .illegal_o(il_b),
      .illegal_cnt_o(cnt_b), .clear_cnt_i(clear_cnt_i)
`ifdef BSG_CACHE_DECODE_STAGE_STATS_EN
      , .ld_cnt_o(ldb), .st_cnt_o(stb), .amo_cnt_o(amob), .mgmt_cnt_o(mgb)
`endif
   );

   wire [15:0] obs_a = {ld_a, st_a, amo_a, mg_a, mk_a, sx_a, size_a, msel_a, asub_a, il_a};
   wire [15:0] obs_b = {ld_b, st_b, amo_b, mg_b, mk_b, sx_b, size_b, msel_b, asub_b, il_b};

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] q_a[$];
   logic [15:0] q_b[$];
   int          occ = 0;
   int          exp_cnt_a = 0;
   int          exp_cnt_b = 0;

   // Reference decode, organised by opcode ranges
   function automatic logic [15:0] ref_dec(input logic [5:0] op, input int dw, input bit amo);
      logic       ld, st, am, mg, mk, sx, il;
      logic [1:0] sz, lo;
      logic [2:0] ms;
      logic [3:0] as;
      int         maxs;
      ld = 0; st = 0; am = 0; mg = 0; mk = 0; sx = 0; il = 0;
      sz = 2'd0; ms = 3'd0; as = 4'd0;
      lo = op[1:0];
      maxs = (dw == 64) ? 3 : 2;
      if (op <= 6'h07) begin
         ld = 1; sx = (op < 6'h04); sz = lo; il = (int'(lo) > maxs);
      end else if (op == 6'h08) begin
         ld = 1; mk = 1; sz = 2'(maxs);
      end else if (op >= 6'h10 && op <= 6'h17) begin
         mg = 1; ms = 3'(op - 6'h10);
      end else if (op >= 6'h20 && op <= 6'h23) begin
         st = 1; sz = lo; il = (int'(lo) > maxs);
      end else if (op == 6'h28) begin
         st = 1; mk = 1; sz = 2'(maxs);
      end else if (amo && op >= 6'h30 && op <= 6'h38) begin
         am = 1; as = 4'(op - 6'h30); sz = 2'(maxs);
      end else begin
         il = 1;
      end
      if (il) return 16'h0001;
      return {ld, st, am, mg, mk, sx, sz, ms, as, 1'b0};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle, entered and left just after a negative edge
   task automatic step(input bit v, input logic [5:0] op, input bit want_yumi, input bit clr);
      bit          yumi, acc;
      logic [15:0] ea, eb;
      yumi = want_yumi && (occ > 0);
      acc  = v && (occ < 2);
      v_i = v; opcode_i = op; yumi_i = yumi; clear_cnt_i = clr;
      #1;
      check("ready_a", 32'(ready_a), 32'(occ < 2));
      check("ready_b", 32'(ready_b), 32'(occ < 2));
      check("v_o_a", 32'(v_a), 32'(occ > 0));
      if (yumi) begin
         ea = q_a.pop_front();
         eb = q_b.pop_front();
         check("dec_a", 32'(obs_a), 32'(ea));
         check("dec_b", 32'(obs_b), 32'(eb));
      end
      if (acc) begin
         ea = ref_dec(op, 64, 1'b1);
         eb = ref_dec(op, 32, 1'b0);
         q_a.push_back(ea);
         q_b.push_back(eb);
         if (!clr && ea[0] && exp_cnt_a < 65535) exp_cnt_a++;
         if (!clr && eb[0] && exp_cnt_b < 3) exp_cnt_b++;
      end
      if (clr) begin
         exp_cnt_a = 0;
         exp_cnt_b = 0;
      end
      occ = occ + int'(acc) - int'(yumi);
      @(posedge clk);
      #1;
      check("cnt_a", 32'(cnt_a), 32'(exp_cnt_a));
      check("cnt_b", 32'(cnt_b), 32'(exp_cnt_b));
      @(negedge clk);
   endtask

   initial begin
      logic [5:0] mix[8];
      mix = '{6'h08, 6'h04, 6'h18, 6'h0C, 6'h2C, 6'h17, 6'h38, 6'h22};

      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("rst_ready", 32'(ready_a), 32'd1);
      check("rst_v", 32'(v_a), 32'd0);
      check("rst_dec_a", 32'(obs_a), 32'd0);
      check("rst_cnt_a", 32'(cnt_a), 32'd0);
      @(negedge clk);

      // 0x03: legal sign-extended double on 64b, oversize on 32b
      step(1, 6'h03, 0, 0);
      step(0, 6'h00, 1, 0);

      // Accept-and-yumi streaming through a single held entry
      step(1, 6'h23, 1, 0);
      step(1, 6'h28, 1, 0);
      step(1, 6'h32, 1, 0);
      step(1, 6'h39, 1, 0);
      for (int i = 0; i < 8; i++) step(1, mix[i], 1, 0);
      step(0, 6'h00, 1, 0);

      // Stall: third opcode held off until the consumer drains
      step(1, 6'h10, 0, 0);
      step(1, 6'h11, 0, 0);
      step(1, 6'h12, 0, 0);
      step(1, 6'h12, 1, 0);
      step(1, 6'h12, 1, 0);
      step(0, 6'h00, 1, 0);
      step(0, 6'h00, 1, 0);

      // Counter saturation on the narrow counter, then clear racing an illegal accept
      for (int i = 0; i < 5; i++) step(1, 6'h39, 1, 0);
      step(1, 6'h39, 1, 1);
      step(0, 6'h00, 1, 0);

      // Asynchronous reset with an entry held and a nonzero count
      for (int i = 0; i < 5; i++) step(1, 6'h18, 1, 0);
      step(1, 6'h10, 0, 0);
      step(0, 6'h00, 0, 0);
      check("pre_rst_v", 32'(v_a), 32'd1);
      check("pre_rst_cnt", 32'(cnt_a), 32'd5);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_v", 32'(v_a), 32'd0);
      check("arst_ready", 32'(ready_a), 32'd1);
      check("arst_cnt", 32'(cnt_a), 32'd0);
      check("arst_dec_a", 32'(obs_a), 32'd0);
      check("arst_dec_b", 32'(obs_b), 32'd0);
      q_a.delete();
      q_b.delete();
      occ = 0;
      exp_cnt_a = 0;
      exp_cnt_b = 0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      step(1, 6'h21, 1, 0);
      step(1, 6'h34, 1, 0);
      step(0, 6'h00, 1, 0);
      step(0, 6'h00, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
